// File: rtl/norm_pkg.sv
// Shared types and constants for the two-pass L1 normalization sequencer.
// The row address width is derived from the depth of the norm row-sum FIFO.
package norm_pkg;

    localparam int NORM_FIFO_DEPTH = 16;
    localparam int ROW_AW          = $clog2(NORM_FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        GAP,
        SYNC,
        DIV,
        DRAIN
    } state_t;

    // A job must hold at least one row and no more rows than the FIFO can hold.
    function automatic logic rows_legal(input int n, input int aw);
        return (n >= 1) && (n <= (1 << aw));
    endfunction

endpackage

// File: rtl/norm_dly_line.sv
// Fixed-length shift register with synchronous reset to zero.
// It keeps the read strobes and addresses aligned with the psum memory latency.
module norm_dly_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/norm_seq_ctrl.sv
// Two-pass (accumulate, then divide) sequencer for the norm unit behind the psum memory.
// Define NORM_PEER_SYNC_EN to add a barrier with the peer core between the two passes.
module norm_seq_ctrl #(
    parameter int ROW_AW  = norm_pkg::ROW_AW,
    parameter int RD_LAT  = 1,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_AW:0]   num_rows,
    output logic              pmem_rd,
    output logic [ROW_AW-1:0] pmem_addr,
    output logic              acc,
    output logic              div,
    output logic              omem_wr,
    output logic [ROW_AW-1:0] omem_addr,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef NORM_PEER_SYNC_EN
    ,
    output logic              peer_rdy_o,
    input  logic              peer_rdy_i
`endif
);

    import norm_pkg::*;

    // GAP covers the acc pipeline drain plus the FIFO settle time.
    localparam int GAP_LEN = RD_LAT + GAP_CYC;
    localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
    localparam int WR_W    = ROW_AW + 2;

    state_t              state_q, state_d;
    logic [ROW_AW:0]     n_q, n_d;
    logic [ROW_AW:0]     cnt_q, cnt_d;
    logic [ROW_AW:0]     cnt_inc;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                err_q, err_d;
    logic                acc_rd_q, acc_rd_d;
    logic                div_rd_q, div_rd_d;
    logic                div_last_q, div_last_d;
    logic [ROW_AW-1:0]   addr_q, addr_d;
    logic [ROW_AW-1:0]   wr_addr_src;
    logic [WR_W-1:0]     wr_din;
    logic [WR_W-1:0]     wr_dout;

    // The row counter is one bit wider than the address so a full 2**ROW_AW job compares cleanly.
    assign cnt_inc = cnt_q + (ROW_AW+1)'(1);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        err_d      = err_q;
        acc_rd_d   = 1'b0;
        div_rd_d   = 1'b0;
        div_last_d = 1'b0;
        addr_d     = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                gap_d = '0;
                if (start) begin
                    if (rows_legal(int'(num_rows), ROW_AW)) begin
                        n_d     = num_rows;
                        state_d = ACC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACC: begin
                acc_rd_d = 1'b1;
                addr_d   = cnt_q[ROW_AW-1:0];
                if (cnt_inc == n_q) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
`ifdef NORM_PEER_SYNC_EN
                    state_d = SYNC;
`else
                    state_d = DIV;
`endif
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            SYNC: begin
`ifdef NORM_PEER_SYNC_EN
                if (peer_rdy_i) begin
                    state_d = DIV;
                end
`else
                state_d = DIV;
`endif
            end
            DIV: begin
                div_rd_d = 1'b1;
                addr_d   = cnt_q[ROW_AW-1:0];
                if (cnt_inc == n_q) begin
                    div_last_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = DRAIN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DRAIN: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            err_q      <= 1'b0;
            acc_rd_q   <= 1'b0;
            div_rd_q   <= 1'b0;
            div_last_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            acc_rd_q   <= acc_rd_d;
            div_rd_q   <= div_rd_d;
            div_last_q <= div_last_d;
            addr_q     <= addr_d;
        end
    end

    norm_dly_line #(.WIDTH(1), .DEPTH(RD_LAT)) u_acc_dly (
        .clk   (clk),
        .reset (reset),
        .din   (acc_rd_q),
        .dout  (acc)
    );

    norm_dly_line #(.WIDTH(1), .DEPTH(RD_LAT)) u_div_dly (
        .clk   (clk),
        .reset (reset),
        .din   (div_rd_q),
        .dout  (div)
    );

    // norm registers its result once more, so the write side trails the reads by RD_LAT+1.
    assign wr_addr_src = div_rd_q ? addr_q : '0;
    assign wr_din      = {div_last_q, wr_addr_src, div_rd_q};

    norm_dly_line #(.WIDTH(WR_W), .DEPTH(RD_LAT + 1)) u_wr_dly (
        .clk   (clk),
        .reset (reset),
        .din   (wr_din),
        .dout  (wr_dout)
    );

    assign {done, omem_addr, omem_wr} = wr_dout;
    assign pmem_rd   = acc_rd_q | div_rd_q;
    assign pmem_addr = addr_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

`ifdef NORM_PEER_SYNC_EN
    assign peer_rdy_o = (state_q == SYNC);
`endif

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// Directed bench for norm_seq_ctrl with hand-derived cycle timing.
// Built with NORM_PEER_SYNC_EN it also exercises the peer barrier.
module tb_norm_seq_ctrl;

    localparam int ROW_AW  = 4;
    localparam int RD_LAT  = 1;
    localparam int GAP_CYC = 2;
`ifdef NORM_PEER_SYNC_EN
    localparam int SYNC_EXTRA = 1;
`else
    localparam int SYNC_EXTRA = 0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic [ROW_AW:0]   num_rows;
    logic              pmem_rd;
    logic [ROW_AW-1:0] pmem_addr;
    logic              acc;
    logic              div;
    logic              omem_wr;
    logic [ROW_AW-1:0] omem_addr;
    logic              busy;
    logic              done;
    logic              err;
`ifdef NORM_PEER_SYNC_EN
    logic              peer_rdy_o;
    logic              peer_rdy_i;
`endif

    int vectors;
    int miscompares;

    int rd_addr[$];
    int wr_addr[$];
    int acc_n, div_n, done_n, done_cyc, first_rd, first_acc, first_div, overlap;
    logic busy_after;

    norm_seq_ctrl #(.ROW_AW(ROW_AW), .RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_rows  (num_rows),
        .pmem_rd   (pmem_rd),
        .pmem_addr (pmem_addr),
        .acc       (acc),
        .div       (div),
        .omem_wr   (omem_wr),
        .omem_addr (omem_addr),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef NORM_PEER_SYNC_EN
        ,
        .peer_rdy_o (peer_rdy_o),
        .peer_rdy_i (peer_rdy_i)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the first cycle after the edge that samples start.
    task automatic run_job(input int n, input bit hammer, input int max_cyc);
        rd_addr.delete();
        wr_addr.delete();
        acc_n = 0; div_n = 0; done_n = 0; overlap = 0;
        done_cyc = -1; first_rd = -1; first_acc = -1; first_div = -1;
        busy_after = 1'b1;
        num_rows = (ROW_AW+1)'(n);
        start = 1'b1;
        step();
        if (!hammer) start = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if (pmem_rd) begin
                rd_addr.push_back(int'(pmem_addr));
                if (first_rd < 0) first_rd = cyc;
            end
            if (acc) begin
                acc_n++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (div) begin
                div_n++;
                if (first_div < 0) first_div = cyc;
            end
            if (acc && div) overlap++;
            if (omem_wr) wr_addr.push_back(int'(omem_addr));
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
                start = 1'b0;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        num_rows = '0;
        repeat (3) step();
        vectors++;
        if ({pmem_rd, pmem_addr, acc, div, omem_wr, omem_addr, busy, done, err} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {pmem_rd, pmem_addr, acc, div, omem_wr, omem_addr, busy, done, err});
        end
`ifdef NORM_PEER_SYNC_EN
        vectors++;
        if (peer_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_peer_rdy_o: got %0b required 0", peer_rdy_o);
        end
`endif
        reset = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: busy %0b err %0b required 0 0", busy, err);
        end
    endtask

    // Full job check: 2N reads in row order, N acc, N div, N writes, single done.
    task automatic test_job(input string nm, input int n, input bit hammer);
        int exp_done;
        exp_done = 2*n + 2*RD_LAT + GAP_CYC + 2 + SYNC_EXTRA;
        run_job(n, hammer, 120);
        vectors++;
        if (done_n !== 1 || done_cyc !== exp_done) begin
            miscompares++;
            $display("FAIL %s_done: got %0d pulses at cycle %0d required 1 at cycle %0d",
                     nm, done_n, done_cyc, exp_done);
        end
        vectors++;
        if (rd_addr.size() !== 2*n || first_rd !== 2) begin
            miscompares++;
            $display("FAIL %s_reads: got %0d reads first at %0d required %0d first at 2",
                     nm, rd_addr.size(), first_rd, 2*n);
        end
        for (int i = 0; i < rd_addr.size() && i < 2*n; i++) begin
            vectors++;
            if (rd_addr[i] !== i % n) begin
                miscompares++;
                $display("FAIL %s_rd_addr[%0d]: got %0d required %0d", nm, i, rd_addr[i], i % n);
            end
        end
        vectors++;
        if (acc_n !== n || first_acc !== 2 + RD_LAT) begin
            miscompares++;
            $display("FAIL %s_acc: got %0d cycles first at %0d required %0d first at %0d",
                     nm, acc_n, first_acc, n, 2 + RD_LAT);
        end
        vectors++;
        if (div_n !== n || first_div !== exp_done - n) begin
            miscompares++;
            $display("FAIL %s_div: got %0d cycles first at %0d required %0d first at %0d",
                     nm, div_n, first_div, n, exp_done - n);
        end
        vectors++;
        if (overlap !== 0) begin
            miscompares++;
            $display("FAIL %s_acc_div_overlap: got %0d required 0", nm, overlap);
        end
        vectors++;
        if (wr_addr.size() !== n) begin
            miscompares++;
            $display("FAIL %s_writes: got %0d required %0d", nm, wr_addr.size(), n);
        end
        for (int i = 0; i < wr_addr.size() && i < n; i++) begin
            vectors++;
            if (wr_addr[i] !== i) begin
                miscompares++;
                $display("FAIL %s_omem_addr[%0d]: got %0d required %0d", nm, i, wr_addr[i], i);
            end
        end
        vectors++;
        if (busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle_after_done: busy %0b required 0", nm, busy_after);
        end
    endtask

    task automatic test_illegal_rows();
        int vals[2];
        logic bad;
        vals[0] = 0;
        vals[1] = 17;
        for (int v = 0; v < 2; v++) begin
            bad = 1'b0;
            num_rows = (ROW_AW+1)'(vals[v]);
            start = 1'b1;
            step();
            start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (busy || pmem_rd) bad = 1'b1;
                step();
            end
            vectors++;
            if (bad !== 1'b0 || err !== 1'b1) begin
                miscompares++;
                $display("FAIL illegal_n%0d: activity %0b err %0b required 0 1", vals[v], bad, err);
            end
        end
        test_job("after_err", 3, 1'b0);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got %0b required 1", err);
        end
    endtask

    task automatic test_reset_mid_div();
        int rd_cnt;
        rd_cnt = 0;
        num_rows = 5'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (pmem_rd) rd_cnt++;
            if (rd_cnt == 7) break;
            step();
        end
        vectors++;
        if (rd_cnt !== 7) begin
            miscompares++;
            $display("FAIL mid_div_reach: got %0d reads required 7", rd_cnt);
        end
        reset = 1'b1;
        step();
        vectors++;
        if ({pmem_rd, pmem_addr, acc, div, omem_wr, omem_addr, busy, done, err} !== 15'd0) begin
            miscompares++;
            $display("FAIL mid_div_reset: got %0h required 0",
                     {pmem_rd, pmem_addr, acc, div, omem_wr, omem_addr, busy, done, err});
        end
        reset = 1'b0;
        step();
        test_job("after_abort", 2, 1'b0);
    endtask

`ifdef NORM_PEER_SYNC_EN
    task automatic test_peer_sync();
        logic bad;
        int   wait_cyc;
        int   dn;
        peer_rdy_i = 1'b0;
        num_rows = 5'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            if (peer_rdy_o) begin
                wait_cyc = k;
                break;
            end
            step();
        end
        vectors++;
        if (wait_cyc !== 8) begin
            miscompares++;
            $display("FAIL sync_entry: peer_rdy_o seen at cycle %0d required 8", wait_cyc);
        end
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (div || pmem_rd || !peer_rdy_o) bad = 1'b1;
            step();
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_hold: got activity %0b required 0", bad);
        end
        peer_rdy_i = 1'b1;
        step();
        vectors++;
        if (peer_rdy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_release: peer_rdy_o %0b required 0", peer_rdy_o);
        end
        step();
        vectors++;
        if (pmem_rd !== 1'b1 || pmem_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL sync_first_read: rd %0b addr %0d required 1 0", pmem_rd, pmem_addr);
        end
        step();
        vectors++;
        if (div !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_first_div: got %0b required 1", div);
        end
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) dn++;
            step();
        end
        vectors++;
        if (dn !== 1) begin
            miscompares++;
            $display("FAIL sync_done: got %0d pulses required 1", dn);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        start = 1'b0;
        num_rows = '0;
`ifdef NORM_PEER_SYNC_EN
        peer_rdy_i = 1'b1;
`endif
        test_reset();
        test_job("basic_n4", 4, 1'b0);
        test_job("full_n16", 16, 1'b0);
        test_illegal_rows();
        test_job("back_to_back_n8", 8, 1'b1);
        test_reset_mid_div();
`ifdef NORM_PEER_SYNC_EN
        test_peer_sync();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
